uart_tx_rx: RTL and testbench

UART_TX_RX -- requirements
Module: uart_tx_rx (top wrapper; instantiates submodules uart_tx and uart_rx, sharing clock and reset)

---
 rtl/uart_tx_rx.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_tx_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_rx.sv
// UART transmitter + receiver sharing one clock and a synchronous
// active-high reset. Frame: start(0), BITS_PER_WORD data LSB first, stop(1).

// Transmitter: registered line output, one word latched per handshake.
module uart_tx #(
  parameter int CLOCKS_PER_PULSE = 10,
  parameter int BITS_PER_WORD    = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     s_valid,
  input  logic [BITS_PER_WORD-1:0] s_data,
  output logic                     s_ready,
  output logic                     tx
);
  localparam int PW = $clog2(CLOCKS_PER_PULSE);
  localparam int BW = $clog2(BITS_PER_WORD + 1);
  localparam logic [PW-1:0] P_LAST = PW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BITS_PER_WORD - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [PW-1:0]            pcnt_q, pcnt_d;
  logic [BW-1:0]            bcnt_q, bcnt_d;
  logic [BITS_PER_WORD-1:0] data_q, data_d;
  logic                     tx_q, tx_d;

  // Ready is gated by reset so it reads 0 during reset and 1 on the
  // very first cycle after reset is released.
  assign s_ready = (state_q == IDLE) & ~rstn;
  assign tx      = tx_q;

  // Next-state: each bit lasts CLOCKS_PER_PULSE cycles; data shifts out LSB first.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    bcnt_d  = bcnt_q;
    data_d  = data_q;
    tx_d    = tx_q;
    if (state_q == IDLE) begin
      if (s_valid) begin
        data_d  = s_data;
        state_d = START;
        tx_d    = 1'b0;
        pcnt_d  = '0;
        bcnt_d  = '0;
      end
    end else if (pcnt_q == P_LAST) begin
      pcnt_d = '0;
      case (state_q)
        START: begin
          state_d = DATA;
          tx_d    = data_q[0];
          data_d  = data_q >> 1;
        end
        DATA: begin
          if (bcnt_q == B_LAST) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
            tx_d   = data_q[0];
            data_d = data_q >> 1;
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end else begin
      pcnt_d = pcnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset; line idles high.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      bcnt_q  <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      bcnt_q  <= bcnt_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end
endmodule

// Receiver: 2-flop synchronizer, centre sampling, framing-error recovery.
module uart_rx #(
  parameter int CLOCKS_PER_PULSE = 10,
  parameter int BITS_PER_WORD    = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rx,
  output logic                     m_valid,
  output logic [BITS_PER_WORD-1:0] m_data
);
  localparam int PW = $clog2(CLOCKS_PER_PULSE);
  localparam int BW = $clog2(BITS_PER_WORD + 1);
  localparam logic [PW-1:0] P_LAST = PW'(CLOCKS_PER_PULSE - 1);
  localparam logic [PW-1:0] H_LAST = PW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BITS_PER_WORD - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]               sync_q;
  logic                     line;
  logic [1:0]               state_q, state_d;
  logic [PW-1:0]            pcnt_q, pcnt_d;
  logic [BW-1:0]            bcnt_q, bcnt_d;
  logic [BITS_PER_WORD-1:0] sr_q, sr_d;
  logic [BITS_PER_WORD-1:0] mdata_q, mdata_d;
  logic                     mvalid_q, mvalid_d;
  logic                     err_q, err_d;   // set after a bad stop bit until line returns high

  assign line    = sync_q[1];
  assign m_valid = mvalid_q;
  assign m_data  = mdata_q;

  // Next-state: find start edge, confirm at half period, then sample every period.
  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    bcnt_d   = bcnt_q;
    sr_d     = sr_q;
    mdata_d  = mdata_q;
    mvalid_d = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (err_q) begin
          if (line) err_d = 1'b0;
        end else if (!line) begin
          state_d = START;
          pcnt_d  = '0;
        end
      end
      START: begin
        if (pcnt_q == H_LAST) begin
          pcnt_d = '0;
          if (line) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bcnt_d  = '0;
          end
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      DATA: begin
        if (pcnt_q == P_LAST) begin
          pcnt_d = '0;
          sr_d   = {line, sr_q[BITS_PER_WORD-1:1]};
          if (bcnt_q == B_LAST) begin
            state_d = STOP;
            bcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      default: begin
        if (pcnt_q == P_LAST) begin
          pcnt_d  = '0;
          state_d = IDLE;
          if (line) begin
            mdata_d  = sr_q;
            mvalid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
    endcase
  end

  // Synchronizer and state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rstn) begin
      sync_q   <= 2'b11;
      state_q  <= IDLE;
      pcnt_q   <= '0;
      bcnt_q   <= '0;
      sr_q     <= '0;
      mdata_q  <= '0;
      mvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], rx};
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      bcnt_q   <= bcnt_d;
      sr_q     <= sr_d;
      mdata_q  <= mdata_d;
      mvalid_q <= mvalid_d;
      err_q    <= err_d;
    end
  end
endmodule

// Top wrapper: independent TX and RX on a shared clock/reset.
module uart_tx_rx #(
  parameter int CLOCKS_PER_PULSE = 10,
  parameter int BITS_PER_WORD    = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     s_valid,
  input  logic [BITS_PER_WORD-1:0] s_data,
  output logic                     s_ready,
  output logic                     tx,
  input  logic                     rx,
  output logic                     m_valid,
  output logic [BITS_PER_WORD-1:0] m_data
);
  uart_tx #(.CLOCKS_PER_PULSE(CLOCKS_PER_PULSE), .BITS_PER_WORD(BITS_PER_WORD)) u_tx (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .tx(tx)
  );

  uart_rx #(.CLOCKS_PER_PULSE(CLOCKS_PER_PULSE), .BITS_PER_WORD(BITS_PER_WORD)) u_rx (
    .clk(clk), .rstn(rstn), .rx(rx), .m_valid(m_valid), .m_data(m_data)
  );
endmodule

// File: tb/tb_uart_tx_rx.sv
// Scoreboard bench for uart_tx_rx: stimulus pushes expected words,
// a monitor pops and compares on every m_valid pulse.
module tb_uart_tx_rx;
  localparam int CPP = 10;
  localparam int BPW = 8;

  logic           clk = 1'b0;
  logic           rstn;
  logic           s_valid;
  logic [BPW-1:0] s_data;
  logic           s_ready;
  logic           tx;
  logic           rx_w;
  logic           m_valid;
  logic [BPW-1:0] m_data;

  logic           lb;
  logic           rx_drv;
  logic [BPW-1:0] exp_q[$];
  logic [BPW-1:0] e;
  int             total = 0;
  int             bad   = 0;

  assign rx_w = lb ? tx : rx_drv;

  uart_tx_rx #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(BPW)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .tx(tx), .rx(rx_w), .m_valid(m_valid), .m_data(m_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every m_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected m_valid m_data=%0h with nothing expected t=%0t", m_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("sb_mdata", {24'h0, m_data}, {24'h0, e});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!s_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("ready_timeout", {31'h0, s_ready}, 32'h1);
  endtask

  // Handshake one word; s_data is scrambled right after to show it is latched.
  task automatic send(input logic [BPW-1:0] d, input bit push);
    wait_ready();
    s_valid = 1'b1;
    s_data  = d;
    if (push) exp_q.push_back(d);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = ~d;
  endtask

  task automatic drive_frame(input logic [BPW-1:0] d, input logic stop_lvl,
                             input int stop_per, input bit push);
    @(negedge clk);
    if (push) exp_q.push_back(d);
    rx_drv = 1'b0;
    repeat (CPP) @(negedge clk);
    for (int i = 0; i < BPW; i++) begin
      rx_drv = d[i];
      repeat (CPP) @(negedge clk);
    end
    rx_drv = stop_lvl;
    repeat (CPP * stop_per) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * CPP) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BPW-1:0] d;
    int             idx;
    int             n;
    logic           ex;

    rstn = 1'b1; s_valid = 1'b0; s_data = '0; lb = 1'b1; rx_drv = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'h0, tx}, 32'h1);
    chk("rst_ready", {31'h0, s_ready}, 32'h0);
    chk("rst_mvalid", {31'h0, m_valid}, 32'h0);
    chk("rst_mdata", {24'h0, m_data}, 32'h0);
    rstn = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'h0, s_ready}, 32'h1);

    // 0xA5 waveform: start 0, bits 1,0,1,0,0,1,0,1, stop 1; ready low 100 cycles
    d = 8'hA5;
    send(d, 1'b1);
    for (int k = 0; k < (BPW + 2) * CPP; k++) begin
      @(negedge clk);
      idx = k / CPP;
      if (idx == 0) ex = 1'b0;
      else if (idx == BPW + 1) ex = 1'b1;
      else ex = d[idx-1];
      chk($sformatf("a5_tx_k%0d", k), {31'h0, tx}, {31'h0, ex});
      chk($sformatf("a5_ready_k%0d", k), {31'h0, s_ready}, 32'h0);
    end
    @(negedge clk);
    chk("a5_ready_back", {31'h0, s_ready}, 32'h1);
    repeat (20) @(negedge clk);

    // loopback sequence
    send(8'hA5, 1'b1);
    send(8'h3C, 1'b1);
    send(8'hF0, 1'b1);
    repeat (120) @(negedge clk);

    // back-to-back 0x00 then 0xFF with s_valid held high
    wait_ready();
    s_valid = 1'b1; s_data = 8'h00;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    @(posedge clk);
    #1 s_data = 8'hFF;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("b2b_ready_low", n, 32'd100);
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(negedge clk);
    chk("b2b_start", {31'h0, tx}, 32'h0);
    repeat (120) @(negedge clk);

    // 3-cycle glitch then a real 0x5A frame
    lb = 1'b0;
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (30) @(negedge clk);
    drive_frame(8'h5A, 1'b1, 1, 1'b1);

    // framing error with the line held low for a while, then 0x3C
    drive_frame(8'h77, 1'b0, 3, 1'b0);
    chk("ferr_mdata_hold", {24'h0, m_data}, 32'h5A);
    drive_frame(8'h3C, 1'b1, 1, 1'b1);
    chk("ferr_next_mdata", {24'h0, m_data}, 32'h3C);

    // reset mid-frame
    lb = 1'b1;
    send(8'hC3, 1'b0);
    repeat (40) @(negedge clk);
    rstn = 1'b1;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      chk($sformatf("mrst_tx_%0d", r), {31'h0, tx}, 32'h1);
      chk($sformatf("mrst_mvalid_%0d", r), {31'h0, m_valid}, 32'h0);
      chk($sformatf("mrst_ready_%0d", r), {31'h0, s_ready}, 32'h0);
      chk($sformatf("mrst_mdata_%0d", r), {24'h0, m_data}, 32'h0);
    end
    rstn = 1'b0;
    @(negedge clk);
    chk("mrst_ready_after", {31'h0, s_ready}, 32'h1);
    repeat (30) @(negedge clk);
    send(8'hC3, 1'b1);
    repeat (120) @(negedge clk);

    // simultaneous send (not looped) and receive
    lb = 1'b0;
    fork
      send(8'h96, 1'b0);
      drive_frame(8'h69, 1'b1, 1, 1'b1);
    join
    repeat (120) @(negedge clk);

    chk("sb_drain", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
